mips_mc_control: RTL

//  Main control FSM of the multicycle MIPS core. Sequences FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/mips_mc_control_if.sv | 37 +++
 rtl/mips_alu_decode.sv | 29 ++
 rtl/mips_mc_control.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operation codes, controller states and datapath mux selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_e;

  // ALU operation for the immediate-form opcodes; ADD for anything else
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_ADDI: code = ALU_ADD;
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      OP_SLTI: code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// mux selects, enables and the ALU operation code out.
interface mips_mc_control_if #(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_source;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal_op;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, dbg_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, dbg_state
  );
endinterface

// File: rtl/mips_alu_decode.sv
// R-type funct field to ALU operation code, with a valid flag for
// functs the core does not implement.
module mips_alu_decode
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               valid
);

  always_comb begin
    alu_op = ALUOP_W'(ALU_ADD);
    valid  = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALUOP_W'(ALU_ADD);
      FN_SUB: alu_op = ALUOP_W'(ALU_SUB);
      FN_AND: alu_op = ALUOP_W'(ALU_AND);
      FN_OR:  alu_op = ALUOP_W'(ALU_OR);
      FN_SLT: alu_op = ALUOP_W'(ALU_SLT);
      default: begin
        alu_op = ALUOP_W'(ALU_ADD);
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS core (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_CTRL_IMM_EN to add the addi/andi/ori/slti IMMEX/IMMWB path.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master bus
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [ALUOP_W-1:0] fn_alu_op_s;
  logic               fn_valid_s;

  logic               pc_write_s, pc_write_cond_s;
  logic               i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
  logic               reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
  logic [1:0]         alu_src_b_s, pc_source_s;
  logic [ALUOP_W-1:0] alu_op_s;

  mips_alu_decode #(.ALUOP_W(ALUOP_W)) u_alu_decode (
    .funct  (bus.funct),
    .alu_op (fn_alu_op_s),
    .valid  (fn_valid_s)
  );

  // Next-state and illegal-instruction detection
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (fn_valid_s) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      // IR is stable for the whole instruction, so opcode still selects lw/sw here
      S_MEMADR: begin
        if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                     state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEMWR;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_IMM_EN
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // State register and the illegal_op pulse flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; FETCH qualifies ir_write/pc_write with the memory handshake
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = SRCB_B;
    pc_source_s     = PCSRC_ALU;
    alu_op_s        = ALUOP_W'(ALU_AND);
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        alu_op_s    = ALUOP_W'(ALU_ADD);
        pc_source_s = PCSRC_ALU;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      S_DECODE: begin
        alu_src_b_s = SRCB_IMM_SH2;
        alu_op_s    = ALUOP_W'(ALU_ADD);
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_B;
        alu_op_s    = fn_alu_op_s;
      end
      S_ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_W'(ALU_ADD);
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        i_or_d_s   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_src_b_s     = SRCB_B;
        alu_op_s        = ALUOP_W'(ALU_SUB);
        pc_source_s     = PCSRC_ALUOUT;
        pc_write_cond_s = 1'b1;
      end
      S_JUMP: begin
        pc_source_s = PCSRC_JUMP;
        pc_write_s  = 1'b1;
      end
`ifdef MC_CTRL_IMM_EN
      S_IMMEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_W'(imm_alu_op(bus.opcode));
      end
      S_IMMWB: begin
        reg_write_s = 1'b1;
      end
`endif
      default: begin
        alu_op_s = ALUOP_W'(ALU_AND);
      end
    endcase
  end

  assign bus.pc_en      = pc_write_s | (pc_write_cond_s & bus.zero);
  assign bus.i_or_d     = i_or_d_s;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.pc_source  = pc_source_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.illegal_op = illegal_q;
  assign bus.dbg_state  = STATE_W'(state_q);

endmodule
